rto_core_param: RTL and testbench

Parametrised real-time-output core. It buffers timestamped words written by the host side and releases each word on the exact cycle its timestamp equals the free-running counter. It generalises the existing RTO core in several ways: data, timestamp and depth are parametric; storage is in-fabric FWFT rather than vendor FIFO IP; late-entry handling is selectable; errors are sticky with a clear input; and a late-event counter is added. It sits between the AXI/host write path and DAC/TTL output drivers.

---
 rtl/rto_pkg.sv | 17 +
 rtl/rto_fwft_fifo.sv | 61 ++++++
 rtl/rto_core_param.sv | 145 ++++++++++++++
 tb/tb_rto_core_param.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rto_pkg.sv
// Shared types and helpers for the real-time-output core.
// Default widths match the original fixed-width RTO core.
package rto_pkg;

  localparam int RTO_TS_W   = 64;
  localparam int RTO_DATA_W = 64;

  typedef struct packed {
    logic [RTO_TS_W-1:0]   ts;
    logic [RTO_DATA_W-1:0] payload;
  } rto_word_t;

  function automatic int rto_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rto_fwft_fifo.sv
// First-word-fall-through FIFO in fabric registers.
// Head word is visible on dout whenever level is non-zero.
module rto_fwft_fifo
  import rto_pkg::*;
#(
  parameter  int DATA_W = 128,
  parameter  int DEPTH  = 1024,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = rto_level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(wr_en) - LW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/rto_core_param.sv
// Real-time-output core: releases buffered words when their
// timestamp meets the global counter, with late/overflow tracking.
module rto_core_param
  import rto_pkg::*;
#(
  parameter  int DATA_W   = RTO_DATA_W,
  parameter  int TS_W     = RTO_TS_W,
  parameter  int DEPTH    = 1024,
  parameter  int AFULL_TH = 1008,
  parameter  int CNT_W    = 32,
  localparam int WW       = TS_W + DATA_W,
  localparam int LW       = rto_level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              auto_start,
  input  logic              late_mode,
  input  logic              err_clear,
  input  logic              wr_valid,
  input  logic [WW-1:0]     wr_data,
  input  logic [TS_W-1:0]   counter,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_late,
  output logic              afull,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              overflow_error,
  output logic [WW-1:0]     overflow_data,
  output logic              timestamp_error,
  output logic [WW-1:0]     timestamp_error_data,
  output logic [CNT_W-1:0]  late_count
);

  logic [WW-1:0]     head;
  logic [TS_W-1:0]   head_ts;
  logic [DATA_W-1:0] head_pl;
  logic [LW-1:0]     lvl;
  logic              wr_en, rd_en;
  logic              cmp_en, hit, late, ovf;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_late_q, out_late_d;
  logic              ovf_err_q, ovf_err_d;
  logic [WW-1:0]     ovf_data_q, ovf_data_d;
  logic              ts_err_q, ts_err_d;
  logic [WW-1:0]     ts_data_q, ts_data_d;
  logic [CNT_W-1:0]  late_cnt_q, late_cnt_d;

  rto_fwft_fifo #(
    .DATA_W (WW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .wr_en   (wr_en),
    .din     (wr_data),
    .rd_en   (rd_en),
    .dout    (head),
    .level   (lvl)
  );

  assign level   = lvl;
  assign empty   = (lvl == '0);
  assign full    = (lvl == LW'(DEPTH));
  assign afull   = (lvl >= LW'(AFULL_TH));
  assign head_ts = head[WW-1:DATA_W];
  assign head_pl = head[DATA_W-1:0];

  // Flush suppresses both the write path and the comparator.
  assign wr_en  = wr_valid && !full && !flush;
  assign ovf    = wr_valid && full && !flush;
  assign cmp_en = auto_start && !empty && !flush;
  assign hit    = cmp_en && (head_ts == counter);
  assign late   = cmp_en && (head_ts < counter);
  assign rd_en  = hit || late;

  always_comb begin
    out_valid_d = hit || (late && late_mode);
    out_late_d  = late && late_mode;
    out_data_d  = out_valid_d ? head_pl : out_data_q;

    ovf_err_d  = ovf_err_q;
    ovf_data_d = ovf_data_q;
    if (err_clear) begin
      ovf_err_d  = 1'b0;
      ovf_data_d = '0;
    end
    if (ovf) begin
      ovf_err_d = 1'b1;
      if (!ovf_err_q || err_clear) ovf_data_d = wr_data;
    end

    ts_err_d  = ts_err_q;
    ts_data_d = ts_data_q;
    late_cnt_d = late_cnt_q;
    if (err_clear) begin
      ts_err_d   = 1'b0;
      ts_data_d  = '0;
      late_cnt_d = '0;
    end
    if (late) begin
      ts_err_d = 1'b1;
      if (!ts_err_q || err_clear) ts_data_d = head;
      if (err_clear) late_cnt_d = CNT_W'(1);
      else if (late_cnt_q != '1) late_cnt_d = late_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_late_q  <= 1'b0;
      ovf_err_q   <= 1'b0;
      ovf_data_q  <= '0;
      ts_err_q    <= 1'b0;
      ts_data_q   <= '0;
      late_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_late_q  <= out_late_d;
      ovf_err_q   <= ovf_err_d;
      ovf_data_q  <= ovf_data_d;
      ts_err_q    <= ts_err_d;
      ts_data_q   <= ts_data_d;
      late_cnt_q  <= late_cnt_d;
    end
  end

  assign out_valid            = out_valid_q;
  assign out_data             = out_data_q;
  assign out_late             = out_late_q;
  assign overflow_error       = ovf_err_q;
  assign overflow_data        = ovf_data_q;
  assign timestamp_error      = ts_err_q;
  assign timestamp_error_data = ts_data_q;
  assign late_count           = late_cnt_q;

endmodule

// File: tb/tb_rto_core_param.sv
// Directed testbench for rto_core_param at default parameters.
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_rto_core_param;

  localparam int TS_W  = 64;
  localparam int DW    = 64;
  localparam int WW    = TS_W + DW;
  localparam int DEPTH = 1024;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n, flush, auto_start, late_mode, err_clear;
  logic            wr_valid;
  logic [WW-1:0]   wr_data;
  logic [TS_W-1:0] counter;
  logic            out_valid, out_late, afull, full, empty;
  logic [DW-1:0]   out_data;
  logic [LW-1:0]   level;
  logic            overflow_error, timestamp_error;
  logic [WW-1:0]   overflow_data, timestamp_error_data;
  logic [31:0]     late_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rto_core_param dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .flush                (flush),
    .auto_start           (auto_start),
    .late_mode            (late_mode),
    .err_clear            (err_clear),
    .wr_valid             (wr_valid),
    .wr_data              (wr_data),
    .counter              (counter),
    .out_valid            (out_valid),
    .out_data             (out_data),
    .out_late             (out_late),
    .afull                (afull),
    .full                 (full),
    .empty                (empty),
    .level                (level),
    .overflow_error       (overflow_error),
    .overflow_data        (overflow_data),
    .timestamp_error      (timestamp_error),
    .timestamp_error_data (timestamp_error_data),
    .late_count           (late_count)
  );

  task automatic chk(input string tag, input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [TS_W-1:0] ts, input logic [DW-1:0] pl);
    wr_valid = 1'b1;
    wr_data  = {ts, pl};
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; auto_start = 1'b0;
    late_mode = 1'b0; err_clear = 1'b0; wr_valid = 1'b0;
    wr_data = '0; counter = '0;
    tick();
    tick();
    chk("rst_valid", WW'(out_valid), WW'(0));
    chk("rst_empty", WW'(empty), WW'(1));
    chk("rst_level", WW'(level), WW'(0));
    chk("rst_full", WW'(full), WW'(0));
    chk("rst_lcnt", WW'(late_count), WW'(0));
    reset_n = 1'b1;
    tick();

    // In-order release at exact timestamps
    wr(64'd100, 64'hA);
    wr(64'd101, 64'hB);
    wr(64'd102, 64'hC);
    chk("lvl3", WW'(level), WW'(3));
    auto_start = 1'b1;
    for (int c = 95; c <= 110; c++) begin
      counter = TS_W'(c);
      tick();
      chk($sformatf("sweep_v%0d", c), WW'(out_valid),
          WW'(c >= 100 && c <= 102));
      if (c >= 100 && c <= 102) begin
        chk($sformatf("sweep_d%0d", c), WW'(out_data), WW'(10 + c - 100));
        chk($sformatf("sweep_l%0d", c), WW'(out_late), WW'(0));
      end
    end
    chk("sweep_empty", WW'(empty), WW'(1));
    chk("sweep_lcnt", WW'(late_count), WW'(0));
    chk("sweep_hold", WW'(out_data), WW'(64'hC));

    // Late entry, drop mode then emit mode
    counter = 64'd60;
    wr(64'd50, 64'h1111);
    chk("late0_wrcyc", WW'(out_valid), WW'(0));
    tick();
    chk("late0_valid", WW'(out_valid), WW'(0));
    chk("late0_err", WW'(timestamp_error), WW'(1));
    chk("late0_data", timestamp_error_data, {64'd50, 64'h1111});
    chk("late0_cnt", WW'(late_count), WW'(1));
    late_mode = 1'b1;
    wr(64'd51, 64'h2222);
    tick();
    chk("late1_valid", WW'(out_valid), WW'(1));
    chk("late1_late", WW'(out_late), WW'(1));
    chk("late1_out", WW'(out_data), WW'(64'h2222));
    chk("late1_keep", timestamp_error_data, {64'd50, 64'h1111});
    chk("late1_cnt", WW'(late_count), WW'(2));
    tick();
    chk("late1_pulse", WW'(out_valid), WW'(0));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clr_err", WW'(timestamp_error), WW'(0));
    chk("clr_data", timestamp_error_data, WW'(0));
    chk("clr_cnt", WW'(late_count), WW'(0));

    // Fill to full, then overflow
    auto_start = 1'b0;
    late_mode  = 1'b0;
    for (int i = 0; i < 1007; i++) wr(TS_W'(1000 + i), DW'(i));
    chk("af_below", WW'(afull), WW'(0));
    wr(64'd5000, 64'h0);
    chk("af_at", WW'(afull), WW'(1));
    chk("af_lvl", WW'(level), WW'(1008));
    for (int i = 0; i < 16; i++) wr(TS_W'(6000 + i), DW'(i));
    chk("full", WW'(full), WW'(1));
    chk("full_lvl", WW'(level), WW'(1024));
    chk("full_noovf", WW'(overflow_error), WW'(0));
    wr(64'd7, 64'hDEAD);
    chk("ovf_err", WW'(overflow_error), WW'(1));
    chk("ovf_data", overflow_data, {64'd7, 64'hDEAD});
    chk("ovf_lvl", WW'(level), WW'(1024));
    wr(64'd8, 64'hBEEF);
    chk("ovf2_data", overflow_data, {64'd7, 64'hDEAD});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush1_lvl", WW'(level), WW'(0));
    chk("flush1_ovf", WW'(overflow_error), WW'(1));

    // Flush with a same-cycle write
    for (int i = 0; i < 10; i++) wr(TS_W'(20 + i), DW'(i));
    chk("f10_lvl", WW'(level), WW'(10));
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = {64'd99, 64'h99};
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    chk("flush2_lvl", WW'(level), WW'(0));
    chk("flush2_empty", WW'(empty), WW'(1));
    chk("flush2_ovfd", overflow_data, {64'd7, 64'hDEAD});
    chk("flush2_tse", WW'(timestamp_error), WW'(0));
    tick();
    chk("flush2_drop", WW'(level), WW'(0));

    // err_clear racing a new late pop
    auto_start = 1'b1;
    counter    = 64'd200;
    wr(64'd150, 64'hAA);
    tick();
    chk("race_pre", timestamp_error_data, {64'd150, 64'hAA});
    chk("race_precnt", WW'(late_count), WW'(1));
    wr(64'd160, 64'hBB);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("race_err", WW'(timestamp_error), WW'(1));
    chk("race_data", timestamp_error_data, {64'd160, 64'hBB});
    chk("race_cnt", WW'(late_count), WW'(1));
    chk("race_ovf", WW'(overflow_error), WW'(0));
    chk("race_ovfd", overflow_data, WW'(0));

    // Reset in the middle of a stream
    auto_start = 1'b0;
    for (int i = 0; i < 6; i++) wr(TS_W'(300 + i), DW'(64'h50 + i));
    auto_start = 1'b1;
    counter    = 64'd300;
    tick();
    chk("mid_valid", WW'(out_valid), WW'(1));
    chk("mid_data", WW'(out_data), WW'(64'h50));
    chk("mid_lvl", WW'(level), WW'(5));
    reset_n = 1'b0;
    counter = 64'd301;
    tick();
    chk("mrst_valid", WW'(out_valid), WW'(0));
    chk("mrst_data", WW'(out_data), WW'(0));
    chk("mrst_lvl", WW'(level), WW'(0));
    chk("mrst_empty", WW'(empty), WW'(1));
    chk("mrst_tse", WW'(timestamp_error), WW'(0));
    chk("mrst_tsd", timestamp_error_data, WW'(0));
    chk("mrst_cnt", WW'(late_count), WW'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
